// File: rtl/alu_issue_stage.sv
// Issue stage: decodes RV64 ALU/LD/SD/branch instructions into ALU operands
// and control, and buffers them in a two-entry valid/ready skid buffer.
module alu_issue_stage #(
   parameter int unsigned XLEN = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_rs1_data,
   input  logic [XLEN-1:0] in_rs2_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] SrcA,
   output logic [XLEN-1:0] SrcB,
   output logic [2:0]      ALUControl,
   output logic [4:0]      out_rd,
   output logic            out_reg_write,
   output logic            out_is_branch,
   output logic            out_illegal
);

   localparam int unsigned IMM_EXT_W = XLEN - 12;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef struct packed {
      logic [XLEN-1:0] src_a;
      logic [XLEN-1:0] src_b;
      logic [2:0]      alu_ctrl;
      logic [4:0]      rd;
      logic            reg_write;
      logic            is_branch;
      logic            illegal;
   } payload_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t   state_q, state_d;
   payload_t out_q, out_d;
   payload_t skid_q, skid_d;
   payload_t dec;
   logic     in_ready_q, in_ready_d;
   logic     out_valid_q, out_valid_d;
   logic     accept, pop;

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [XLEN-1:0] imm_i, imm_s;
   logic            unused_rs1_idx;

   assign opcode         = in_instr[6:0];
   assign funct3         = in_instr[14:12];
   assign imm_i          = {{IMM_EXT_W{in_instr[31]}}, in_instr[31:20]};
   assign imm_s          = {{IMM_EXT_W{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   // rs1 index is resolved upstream; only its data arrives here
   assign unused_rs1_idx = ^in_instr[19:15];

   // Decode the incoming instruction into an issue payload
   always_comb begin
      dec           = '0;
      dec.src_a     = in_rs1_data;
      dec.src_b     = in_rs2_data;
      dec.alu_ctrl  = ALU_ADD;
      dec.rd        = in_instr[11:7];
      dec.reg_write = 1'b0;
      dec.is_branch = 1'b0;
      dec.illegal   = 1'b0;
      unique case (opcode)
         OP_R: begin
            dec.reg_write = 1'b1;
            case (funct3)
               3'b000:  dec.alu_ctrl = in_instr[30] ? ALU_SUB : ALU_ADD;
               3'b010:  dec.alu_ctrl = ALU_SLT;
               3'b110:  dec.alu_ctrl = ALU_OR;
               3'b111:  dec.alu_ctrl = ALU_AND;
               default: dec.illegal  = 1'b1;
            endcase
         end
         OP_I: begin
            dec.src_b     = imm_i;
            dec.reg_write = 1'b1;
            case (funct3)
               3'b000:  dec.alu_ctrl = ALU_ADD;
               3'b010:  dec.alu_ctrl = ALU_SLT;
               3'b110:  dec.alu_ctrl = ALU_OR;
               3'b111:  dec.alu_ctrl = ALU_AND;
               default: dec.illegal  = 1'b1;
            endcase
         end
         OP_LOAD: begin
            dec.src_b     = imm_i;
            dec.reg_write = 1'b1;
            dec.illegal   = (funct3 != 3'b011);
         end
         OP_STORE: begin
            dec.src_b   = imm_s;
            dec.illegal = (funct3 != 3'b011);
         end
         OP_BRANCH: begin
            if ((funct3 == 3'b000) || (funct3 == 3'b001)) begin
               dec.alu_ctrl  = ALU_SUB;
               dec.is_branch = 1'b1;
            end else begin
               dec.illegal = 1'b1;
            end
         end
         default: dec.illegal = 1'b1;
      endcase
      // Illegal encodings carry a neutral control word
      if (dec.illegal) begin
         dec.alu_ctrl  = ALU_ADD;
         dec.reg_write = 1'b0;
         dec.is_branch = 1'b0;
      end
      if (dec.rd == 5'd0) begin
         dec.reg_write = 1'b0;
      end
   end

   assign accept = in_valid & in_ready_q;
   assign pop    = out_valid_q & out_ready;

   // Skid-buffer next state: output register, skid register, ready/valid
   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      skid_d  = skid_q;
      unique case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d = ONE;
               out_d   = dec;
            end
         end
         ONE: begin
            if (accept && pop) begin
               out_d = dec;
            end else if (accept) begin
               state_d = FULL;
               skid_d  = dec;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (pop) begin
               state_d = ONE;
               out_d   = skid_q;
            end
         end
         default: state_d = EMPTY;
      endcase
      // Squash wins over everything; a same-cycle pop simply is not refilled
      if (flush) begin
         state_d = EMPTY;
         out_d   = out_q;
         skid_d  = skid_q;
      end
      in_ready_d  = (state_d != FULL);
      out_valid_d = (state_d != EMPTY);
   end

   // State and payload registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= EMPTY;
         out_q       <= '0;
         skid_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_q       <= out_d;
         skid_q      <= skid_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready      = in_ready_q;
   assign out_valid     = out_valid_q;
   assign SrcA          = out_q.src_a;
   assign SrcB          = out_q.src_b;
   assign ALUControl    = out_q.alu_ctrl;
   assign out_rd        = out_q.rd;
   assign out_reg_write = out_q.reg_write;
   assign out_is_branch = out_q.is_branch;
   assign out_illegal   = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode, handshake, flush and reset.
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [63:0] in_rs1_data;
   logic [63:0] in_rs2_data;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] SrcA;
   logic [63:0] SrcB;
   logic [2:0]  ALUControl;
   logic [4:0]  out_rd;
   logic        out_reg_write;
   logic        out_is_branch;
   logic        out_illegal;

   int n_cmp = 0;
   int n_err = 0;

   alu_issue_stage #(.XLEN(64)) dut (
      .clk           (clk),
      .reset         (reset),
      .flush         (flush),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_instr      (in_instr),
      .in_rs1_data   (in_rs1_data),
      .in_rs2_data   (in_rs2_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .SrcA          (SrcA),
      .SrcB          (SrcB),
      .ALUControl    (ALUControl),
      .out_rd        (out_rd),
      .out_reg_write (out_reg_write),
      .out_is_branch (out_is_branch),
      .out_illegal   (out_illegal)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] i, input logic [63:0] a, input logic [63:0] b);
      in_valid    = v;
      in_instr    = i;
      in_rs1_data = a;
      in_rs2_data = b;
   endtask

   // Push one instruction into an empty stage with out_ready=1; outputs then hold it
   task automatic issue_one(input logic [31:0] i, input logic [63:0] a, input logic [63:0] b);
      out_ready = 1'b1;
      drive(1'b1, i, a, b);
      step();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
      drive(1'b0, 32'h0, 64'h0, 64'h0);
      #2;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
      n_cmp++; if (SrcA !== 64'h0 || SrcB !== 64'h0) begin n_err++; $display("FAIL reset_src got %h/%h want 0/0", SrcA, SrcB); end
      n_cmp++; if (ALUControl !== 3'b000) begin n_err++; $display("FAIL reset_alu got %b want 000", ALUControl); end
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic test_sub();
      issue_one(32'h402081B3, 64'd10, 64'd3);
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL sub_valid got %0b want 1", out_valid); end
      n_cmp++; if (ALUControl !== 3'b001) begin n_err++; $display("FAIL sub_alu got %b want 001", ALUControl); end
      n_cmp++; if (SrcA !== 64'd10 || SrcB !== 64'd3) begin n_err++; $display("FAIL sub_src got %0d/%0d want 10/3", SrcA, SrcB); end
      n_cmp++; if (out_rd !== 5'd3 || out_reg_write !== 1'b1) begin n_err++; $display("FAIL sub_rd got rd=%0d rw=%0b want 3/1", out_rd, out_reg_write); end
      n_cmp++; if (out_is_branch !== 1'b0 || out_illegal !== 1'b0) begin n_err++; $display("FAIL sub_flags got br=%0b ill=%0b want 0/0", out_is_branch, out_illegal); end
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL sub_drain got %0b want 0", out_valid); end
   endtask

   task automatic test_r_type();
      logic [31:0] instr_t [4];
      logic [2:0]  alu_t   [4];
      instr_t[0] = 32'h002081B3; alu_t[0] = 3'b000;  // ADD
      instr_t[1] = 32'h0020A1B3; alu_t[1] = 3'b101;  // SLT
      instr_t[2] = 32'h0020E1B3; alu_t[2] = 3'b011;  // OR
      instr_t[3] = 32'h0020F1B3; alu_t[3] = 3'b010;  // AND
      for (int k = 0; k < 4; k++) begin
         issue_one(instr_t[k], 64'd7, 64'd9);
         n_cmp++; if (ALUControl !== alu_t[k] || SrcB !== 64'd9) begin n_err++; $display("FAIL rtype_%0d got alu=%b srcb=%0d want %b/9", k, ALUControl, SrcB, alu_t[k]); end
         n_cmp++; if (out_reg_write !== 1'b1 || out_illegal !== 1'b0) begin n_err++; $display("FAIL rtype_rw_%0d got rw=%0b ill=%0b want 1/0", k, out_reg_write, out_illegal); end
         step();
      end
   endtask

   task automatic test_i_type();
      issue_one(32'hFFF00293, 64'd0, 64'd55);  // ADDI x5,x0,-1
      n_cmp++; if (ALUControl !== 3'b000 || SrcB !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL addi got alu=%b srcb=%h want 000/ffffffffffffffff", ALUControl, SrcB); end
      n_cmp++; if (out_rd !== 5'd5 || out_reg_write !== 1'b1 || SrcA !== 64'd0) begin n_err++; $display("FAIL addi_rd got rd=%0d rw=%0b a=%0d want 5/1/0", out_rd, out_reg_write, SrcA); end
      step();
      issue_one(32'h07F0E293, 64'd4, 64'd55);  // ORI x5,x1,127
      n_cmp++; if (ALUControl !== 3'b011 || SrcB !== 64'd127) begin n_err++; $display("FAIL ori got alu=%b srcb=%0d want 011/127", ALUControl, SrcB); end
      step();
      issue_one(32'h0100B283, 64'd4, 64'd55);  // LD x5,16(x1)
      n_cmp++; if (ALUControl !== 3'b000 || SrcB !== 64'd16 || out_reg_write !== 1'b1) begin n_err++; $display("FAIL ld got alu=%b srcb=%0d rw=%0b want 000/16/1", ALUControl, SrcB, out_reg_write); end
      step();
   endtask

   task automatic test_store();
      issue_one(32'h0020B423, 64'd100, 64'd77);  // SD x2,8(x1)
      n_cmp++; if (ALUControl !== 3'b000 || SrcB !== 64'd8) begin n_err++; $display("FAIL sd got alu=%b srcb=%0d want 000/8", ALUControl, SrcB); end
      n_cmp++; if (out_reg_write !== 1'b0 || SrcA !== 64'd100) begin n_err++; $display("FAIL sd_rw got rw=%0b a=%0d want 0/100", out_reg_write, SrcA); end
      step();
   endtask

   task automatic test_branch();
      issue_one(32'h00209463, 64'd5, 64'd6);  // BNE x1,x2,8
      n_cmp++; if (ALUControl !== 3'b001 || out_is_branch !== 1'b1) begin n_err++; $display("FAIL bne got alu=%b br=%0b want 001/1", ALUControl, out_is_branch); end
      n_cmp++; if (out_reg_write !== 1'b0 || SrcB !== 64'd6) begin n_err++; $display("FAIL bne_rw got rw=%0b srcb=%0d want 0/6", out_reg_write, SrcB); end
      step();
   endtask

   task automatic test_illegal();
      issue_one(32'h0000007F, 64'd1, 64'd2);
      n_cmp++; if (out_illegal !== 1'b1 || ALUControl !== 3'b000 || out_reg_write !== 1'b0) begin n_err++; $display("FAIL ill_op got ill=%0b alu=%b rw=%0b want 1/000/0", out_illegal, ALUControl, out_reg_write); end
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL ill_valid got %0b want 1", out_valid); end
      step();
      issue_one(32'h002091B3, 64'd1, 64'd2);  // R-type funct3 001
      n_cmp++; if (out_illegal !== 1'b1 || ALUControl !== 3'b000 || out_reg_write !== 1'b0 || out_is_branch !== 1'b0) begin n_err++; $display("FAIL ill_f3 got ill=%0b alu=%b rw=%0b br=%0b want 1/000/0/0", out_illegal, ALUControl, out_reg_write, out_is_branch); end
      step();
   endtask

   task automatic test_rd_zero();
      issue_one(32'h00208033, 64'd1, 64'd2);  // ADD x0,x1,x2
      n_cmp++; if (out_reg_write !== 1'b0 || out_illegal !== 1'b0 || out_rd !== 5'd0) begin n_err++; $display("FAIL rd0 got rw=%0b ill=%0b rd=%0d want 0/0/0", out_reg_write, out_illegal, out_rd); end
      step();
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      drive(1'b1, 32'h00100293, 64'd1, 64'd0);  // A
      step();
      drive(1'b1, 32'h00200293, 64'd2, 64'd0);  // B
      step();
      n_cmp++; if (in_ready !== 1'b0 || SrcA !== 64'd1 || out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_full got rdy=%0b a=%0d v=%0b want 0/1/1", in_ready, SrcA, out_valid); end
      drive(1'b1, 32'h00300293, 64'd3, 64'd0);  // C held by decode
      step();
      n_cmp++; if (in_ready !== 1'b0 || SrcA !== 64'd1 || SrcB !== 64'd1) begin n_err++; $display("FAIL b2b_hold got rdy=%0b a=%0d b=%0d want 0/1/1", in_ready, SrcA, SrcB); end
      out_ready = 1'b1;
      step();
      n_cmp++; if (SrcA !== 64'd2 || in_ready !== 1'b1 || SrcB !== 64'd2) begin n_err++; $display("FAIL b2b_b got a=%0d b=%0d rdy=%0b want 2/2/1", SrcA, SrcB, in_ready); end
      step();
      in_valid = 1'b0;
      n_cmp++; if (SrcA !== 64'd3 || out_valid !== 1'b1 || SrcB !== 64'd3) begin n_err++; $display("FAIL b2b_c got a=%0d b=%0d v=%0b want 3/3/1", SrcA, SrcB, out_valid); end
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain got %0b want 0", out_valid); end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      drive(1'b1, 32'h00100293, 64'd11, 64'd0);
      step();
      drive(1'b1, 32'h00200293, 64'd12, 64'd0);
      step();
      drive(1'b1, 32'h00300293, 64'd13, 64'd0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL flush got v=%0b rdy=%0b want 0/1", out_valid, in_ready); end
      out_ready = 1'b1;
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_drop got v=%0b want 0", out_valid); end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      drive(1'b1, 32'h402081B3, 64'd21, 64'd22);
      step();
      drive(1'b1, 32'h402081B3, 64'd23, 64'd24);
      step();
      in_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid got v=%0b rdy=%0b want 0/1", out_valid, in_ready); end
      n_cmp++; if (SrcA !== 64'h0 || SrcB !== 64'h0 || ALUControl !== 3'b000) begin n_err++; $display("FAIL rstmid_payload got %h/%h/%b want 0/0/000", SrcA, SrcB, ALUControl); end
      step();
      reset = 1'b0;
      out_ready = 1'b1;
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_after got v=%0b want 0", out_valid); end
   endtask

   initial begin
      test_reset();
      test_sub();
      test_r_type();
      test_i_type();
      test_store();
      test_branch();
      test_illegal();
      test_rd_zero();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
